// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART transmitter states, framing constants and byte helper.
// UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_TX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP
   } uart_tx_state_e;

   localparam logic START_LEVEL = 1'b0;
   localparam logic IDLE_LEVEL  = 1'b1;
   localparam int   DATA_BITS   = 8;

   function automatic int bytes_per_word(input int word_w);
      return word_w / DATA_BITS;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - loadable bit-time down-counter, pulses bit_end every div+1 cycles.
module uart_baud_tick #(
   parameter int DIV_W = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic             i_run,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_bit_end
);

   logic [DIV_W-1:0] r_cnt;

   // Auto-reloads on expiry so consecutive bits need no extra load cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_div;
      end else if (!i_run) begin
         r_cnt <= '0;
      end else if (r_cnt == '0) begin
         r_cnt <= i_div;
      end else begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_bit_end = i_run && (r_cnt == '0);

endmodule

// File: rtl/uart_buf_tx.sv
// rtl/uart_buf_tx.sv - multi-word buffer UART transmitter with start/busy/done handshake.
// UART_TX_PARITY_EN adds the parity_odd port and a parity bit per frame.
module uart_buf_tx
   import uart_pkg::*;
#(
   parameter int CLOCK_SPEED = 100_000_000,
   parameter int BAUD_RATE   = 115200,
   parameter int WORD_W      = 64,
   parameter int WORDS       = 8,
   parameter int STOP_BITS   = 1,
   parameter int DIV_W       = 20,
   localparam int BPW        = bytes_per_word(WORD_W),
   localparam int WPOS_W     = (WORDS > 1) ? $clog2(WORDS) : 1,
   localparam int BPOS_W     = (BPW > 1) ? $clog2(BPW) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [WORDS*WORD_W-1:0] data_buffer,
   input  logic                    endianness,
   input  logic                    start,
   input  logic [DIV_W-1:0]        div,
`ifdef UART_TX_PARITY_EN
   input  logic                    parity_odd,
`endif
   output logic                    tx,
   output logic                    busy,
   output logic                    done,
   output logic [WPOS_W-1:0]       wordpos,
   output logic [BPOS_W-1:0]       bytepos,
   output logic                    bytestart,
   output logic                    byteend
);

   localparam int DEFAULT_DIV = CLOCK_SPEED / BAUD_RATE - 1;

   uart_tx_state_e      r_state;
   logic [DIV_W-1:0]    r_div;
   logic                r_endian;
   logic [7:0]          r_shift;
   logic [2:0]          r_bit_cnt;
   logic [1:0]          r_stop_cnt;
   logic                r_tx;
   logic                r_busy;
   logic                r_bytestart;
   logic [WPOS_W-1:0]   r_wordpos;
   logic [BPOS_W-1:0]   r_bytepos;
`ifdef UART_TX_PARITY_EN
   logic                r_parity_odd;
   logic                r_parity_bit;
   logic                w_parity_odd;
`endif

   logic                w_idle;
   logic                w_bit_end;
   logic [DIV_W-1:0]    w_div;
   logic                w_word_end;
   logic                w_last;
   logic                w_stop_last;
   logic [WPOS_W-1:0]   w_adv_word;
   logic [BPOS_W-1:0]   w_adv_byte;
   logic [WPOS_W-1:0]   w_ld_word;
   logic [BPOS_W-1:0]   w_ld_byte;
   logic                w_ld_endian;
   logic [BPOS_W-1:0]   w_phys;
   logic [7:0]          w_ld_data;

   assign w_idle      = (r_state == ST_IDLE);
   assign w_div       = w_idle ? div : r_div;
   assign w_word_end  = (r_bytepos == BPOS_W'(BPW - 1));
   assign w_last      = w_word_end && (r_wordpos == WPOS_W'(WORDS - 1));
   assign w_stop_last = (r_stop_cnt == 2'(STOP_BITS - 1));
   assign w_adv_byte  = w_word_end ? '0 : r_bytepos + 1'b1;
   assign w_adv_word  = w_word_end ? r_wordpos + 1'b1 : r_wordpos;
`ifdef UART_TX_PARITY_EN
   assign w_parity_odd = w_idle ? parity_odd : r_parity_odd;
`endif

   // The byte about to be loaded: word 0/byte 0 from IDLE, otherwise the next position.
   always_comb begin
      w_ld_word   = w_idle ? '0 : w_adv_word;
      w_ld_byte   = w_idle ? '0 : w_adv_byte;
      w_ld_endian = w_idle ? endianness : r_endian;
      w_phys      = w_ld_endian ? BPOS_W'(BPW - 1) - w_ld_byte : w_ld_byte;
      w_ld_data   = '0;
      for (int w = 0; w < WORDS; w++) begin
         for (int b = 0; b < BPW; b++) begin
            if (w_ld_word == WPOS_W'(w) && w_phys == BPOS_W'(b)) begin
               w_ld_data = data_buffer[w*WORD_W + b*8 +: 8];
            end
         end
      end
   end

   uart_baud_tick #(.DIV_W(DIV_W)) u_baud (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_idle && start),
      .i_run     (r_busy),
      .i_div     (w_div),
      .o_bit_end (w_bit_end)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_div       <= DIV_W'(DEFAULT_DIV);
         r_endian    <= 1'b0;
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_stop_cnt  <= '0;
         r_tx        <= IDLE_LEVEL;
         r_busy      <= 1'b0;
         r_bytestart <= 1'b0;
         r_wordpos   <= '0;
         r_bytepos   <= '0;
`ifdef UART_TX_PARITY_EN
         r_parity_odd <= 1'b0;
         r_parity_bit <= 1'b0;
`endif
      end else begin
         r_bytestart <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_div       <= div;
                  r_endian    <= endianness;
                  r_wordpos   <= '0;
                  r_bytepos   <= '0;
                  r_shift     <= w_ld_data;
                  r_tx        <= START_LEVEL;
                  r_busy      <= 1'b1;
                  r_bytestart <= 1'b1;
                  r_state     <= ST_START;
`ifdef UART_TX_PARITY_EN
                  r_parity_odd <= parity_odd;
                  r_parity_bit <= (^w_ld_data) ^ w_parity_odd;
`endif
               end
            end
            ST_START: begin
               if (w_bit_end) begin
                  r_tx      <= r_shift[0];
                  r_bit_cnt <= '0;
                  r_state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_bit_end) begin
                  if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                     r_tx       <= r_parity_bit;
                     r_state    <= ST_PARITY;
`else
                     r_tx       <= IDLE_LEVEL;
                     r_stop_cnt <= '0;
                     r_state    <= ST_STOP;
`endif
                  end else begin
                     r_shift   <= r_shift >> 1;
                     r_tx      <= r_shift[1];
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (w_bit_end) begin
                  r_tx       <= IDLE_LEVEL;
                  r_stop_cnt <= '0;
                  r_state    <= ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               if (w_bit_end) begin
                  if (!w_stop_last) begin
                     r_stop_cnt <= r_stop_cnt + 1'b1;
                  end else if (w_last) begin
                     r_busy  <= 1'b0;
                     r_state <= ST_IDLE;
                  end else begin
                     // Back-to-back frames: next start bit follows the stop bit directly.
                     r_wordpos   <= w_adv_word;
                     r_bytepos   <= w_adv_byte;
                     r_shift     <= w_ld_data;
                     r_tx        <= START_LEVEL;
                     r_bytestart <= 1'b1;
                     r_state     <= ST_START;
`ifdef UART_TX_PARITY_EN
                     r_parity_bit <= (^w_ld_data) ^ w_parity_odd;
`endif
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign tx        = r_tx;
   assign busy      = r_busy;
   assign wordpos   = r_wordpos;
   assign bytepos   = r_bytepos;
   assign bytestart = r_bytestart;
   assign byteend   = (r_state == ST_STOP) && w_bit_end && w_stop_last;
   assign done      = byteend && w_last;

endmodule

// File: tb/tb_uart_buf_tx.sv
// tb/tb_uart_buf_tx.sv - scoreboard bench for uart_buf_tx (dut0: 1 stop bit, dut1: 2 stop bits).
module tb_uart_buf_tx;

`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   typedef struct {
      logic [7:0] data;
      int         wpos;
      int         bpos;
      bit         last;
      int         dv;
      bit         podd;
   } item_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] data_buffer = '0;
   logic        endianness = 1'b0;
   logic [19:0] div = '0;
   logic        parity_odd = 1'b0;
   logic [1:0]  start = '0;
   logic [1:0]  tx, busy, done, bs, be, wp, bp;

   int    n_checks = 0;
   int    n_fail = 0;
   item_t q0[$];
   item_t q1[$];
   bit    m_act[2];
   int    m_cyc[2];
   item_t m_it[2];

   always #5 clk = ~clk;

   uart_buf_tx #(.WORD_W(16), .WORDS(2), .STOP_BITS(1), .DIV_W(20)) u_dut0 (
      .clk(clk), .rst(rst), .data_buffer(data_buffer), .endianness(endianness),
      .start(start[0]), .div(div),
`ifdef UART_TX_PARITY_EN
      .parity_odd(parity_odd),
`endif
      .tx(tx[0]), .busy(busy[0]), .done(done[0]), .wordpos(wp[0]), .bytepos(bp[0]),
      .bytestart(bs[0]), .byteend(be[0]));

   uart_buf_tx #(.WORD_W(16), .WORDS(2), .STOP_BITS(2), .DIV_W(20)) u_dut1 (
      .clk(clk), .rst(rst), .data_buffer(data_buffer), .endianness(endianness),
      .start(start[1]), .div(div),
`ifdef UART_TX_PARITY_EN
      .parity_odd(parity_odd),
`endif
      .tx(tx[1]), .busy(busy[1]), .done(done[1]), .wordpos(wp[1]), .bytepos(bp[1]),
      .bytestart(bs[1]), .byteend(be[1]));

   task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: actual %0h required %0h at %0t", name, d, act, exp, $time);
      end
   endtask

   function automatic int stops(input int d);
      return (d == 0) ? 1 : 2;
   endfunction

   function automatic bit exp_bit(input item_t it, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return it.data[idx-1];
      if (P == 1 && idx == 9) return (^it.data) ^ it.podd;
      return 1'b1;
   endfunction

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   task automatic push_buf(input int d, input logic [31:0] b, input bit e, input int dv, input bit po);
      item_t it;
      for (int w = 0; w < 2; w++) begin
         for (int k = 0; k < 2; k++) begin
            int phys = e ? 1 - k : k;
            it.data = b[w*16 + phys*8 +: 8];
            it.wpos = w;
            it.bpos = k;
            it.last = (w == 1 && k == 1);
            it.dv   = dv;
            it.podd = po;
            if (d == 0) q0.push_back(it); else q1.push_back(it);
         end
      end
   endtask

   task automatic mon_step(input int d);
      item_t it;
      int    len;
      if (bs[d]) begin
         check("bytestart_overlap", d, m_act[d], 0);
         check("bytestart_pending", d, qsize(d) > 0, 1);
         if (qsize(d) > 0) begin
            it = (d == 0) ? q0.pop_front() : q1.pop_front();
            check("wordpos", d, wp[d], it.wpos);
            check("bytepos", d, bp[d], it.bpos);
            m_it[d]  = it;
            m_act[d] = 1'b1;
            m_cyc[d] = 0;
         end
      end
      if (m_act[d]) begin
         it  = m_it[d];
         len = (9 + P + stops(d)) * (it.dv + 1);
         check("tx_bit", d, tx[d], exp_bit(it, m_cyc[d] / (it.dv + 1)));
         check("busy_frame", d, busy[d], 1);
         check("byteend", d, be[d], m_cyc[d] == len - 1);
         check("done", d, done[d], (m_cyc[d] == len - 1) && it.last);
         m_cyc[d]++;
         if (m_cyc[d] == len) m_act[d] = 1'b0;
      end else begin
         check("idle_tx", d, tx[d], 1);
         check("idle_busy", d, busy[d], 0);
         check("idle_byteend", d, be[d], 0);
         check("idle_done", d, done[d], 0);
      end
      if (rst) begin
         m_act[d] = 1'b0;
         if (d == 0) q0.delete(); else q1.delete();
      end
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) mon_step(d);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int d);
      int n = 0;
      @(negedge clk);
      while (busy[d] && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", d, busy[d], 0);
      check("queue_drained", d, qsize(d), 0);
   endtask

   task automatic run_buf(input int d, input logic [31:0] b, input bit e, input int dv,
                          input bit po, input bit spam);
      wait_idle(d);
      tick();
      data_buffer = b;
      endianness  = e;
      div         = 20'(dv);
      parity_odd  = po;
      push_buf(d, b, e, dv, po);
      start[d] = 1'b1;
      tick();
      start[d] = 1'b0;
      @(negedge clk);
      check("start_bytestart", d, bs[d], 1);
      check("start_tx", d, tx[d], 0);
      check("start_busy", d, busy[d], 1);
      if (spam) begin
         repeat (3) tick();
         start[d] = 1'b1;
         tick();
         start[d] = 1'b0;
      end
      wait_idle(d);
   endtask

   initial begin
      int gap;
      int n;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      check("reset_wordpos", 0, wp[0], 0);
      check("reset_bytepos", 0, bp[0], 0);
      check("reset_bytestart", 1, bs[1], 0);
      repeat (100) tick();

      run_buf(0, 32'h3C01_12A5, 1'b0, 3, 1'b0, 1'b0);
      run_buf(0, 32'h3C01_12A5, 1'b1, 3, 1'b0, 1'b0);
      run_buf(1, $urandom, 1'b0, 0, 1'b0, 1'b1);

      // Reset during DATA bit 4 of byte 1, then a clean restart.
      wait_idle(0);
      tick();
      data_buffer = 32'h3C01_12A5;
      endianness  = 1'b0;
      div         = 20'd3;
      push_buf(0, data_buffer, 1'b0, 3, 1'b0);
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      repeat (61) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("midrst_tx", 0, tx[0], 1);
      check("midrst_busy", 0, busy[0], 0);
      check("midrst_bytepos", 0, bp[0], 0);
      run_buf(0, 32'h3C01_12A5, 1'b0, 3, 1'b0, 1'b0);

      run_buf(0, 32'h0000_00A5, 1'b0, 3, 1'b0, 1'b0);
      run_buf(0, 32'h0000_00A5, 1'b0, 3, 1'b1, 1'b0);

      for (int i = 0; i < 8; i++) begin
         run_buf(int'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
      end

      // start held high: second buffer begins after exactly one idle cycle.
      wait_idle(0);
      tick();
      data_buffer = $urandom;
      endianness  = 1'b1;
      div         = 20'd1;
      push_buf(0, data_buffer, 1'b1, 1, 1'b0);
      push_buf(0, data_buffer, 1'b1, 1, 1'b0);
      start[0] = 1'b1;
      n = 0;
      @(negedge clk);
      while (!busy[0] && n < 10) begin @(negedge clk); n++; end
      while (busy[0] && n < 3000) begin @(negedge clk); n++; end
      gap = 0;
      while (!busy[0] && n < 3000) begin @(negedge clk); gap++; n++; end
      check("held_start_gap", 0, gap, 1);
      tick();
      start[0] = 1'b0;
      wait_idle(0);

      repeat (5) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_buf_tx.md
# uart_buf_tx

Parametrised UART transmitter that serialises a multi-word buffer as standard 8-bit UART frames, with a start bit, optional parity, 1 or 2 stop bits and a runtime baud divisor. It replaces the earlier raw bit-streaming transmitter: word count, word width and framing are generic, byte order is selectable, and a start/busy/done handshake is added. It sits between the host-side buffer logic and the board TX pin.

## Interface
- `CLOCK_SPEED`, 100_000_000: system clock in Hz; documentation and default-divisor use only.
- `BAUD_RATE`, 115200: nominal baud rate; `CLOCK_SPEED/BAUD_RATE-1` is the expected `div` value.
- `WORD_W`, 64: bits per buffer word; must be a multiple of 8. BPW = `WORD_W/8` bytes per word.
- `WORDS`, 8: words per buffer, at least 1.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `DIV_W`, 20: width of the divisor.
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `data_buffer`  in  WORDS*WORD_W  flat buffer; word w occupies bits [w*WORD_W +: WORD_W].
- `endianness`  in  1  1: big (byte BPW-1 of each word sent first), 0: little (byte 0 first); sampled at `start`.
- `start`  in  1  request one buffer transmission; honoured only in IDLE.
- `div`  in  DIV_W  clock cycles per bit minus 1; sampled at `start`.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  transmission in progress.
- `done`  out  1  one-cycle pulse at end of buffer.
- `wordpos`  out  $clog2(WORDS) (minimum 1)  index of the word being sent.
- `bytepos`  out  $clog2(BPW) (minimum 1)  logical byte index within the word (0 = first sent).
- `bytestart`  out  1  one-cycle pulse on the first cycle of each start bit.
- `byteend`  out  1  one-cycle pulse on the last cycle of each frame's final stop bit.

## Operation
- States: IDLE, START, DATA, PARITY (present only under the macro), STOP.
- IDLE with `start=1`:
  - Latch `div` and `endianness`.
  - Clear `wordpos` and `bytepos`.
  - Load the selected byte into the shift register.
  - Enter START.
- START: `tx=0` for div+1 cycles, then DATA.
- DATA: 8 bits, LSB first, each bit held for div+1 cycles. After bit 7, go to PARITY if enabled, otherwise STOP.
- STOP: `tx=1` for STOP_BITS*(div+1) cycles. Then:
  - If this is not the last byte: advance `bytepos`; on wrap to 0, increment `wordpos`. Load the next byte and enter START directly, with no idle gap.
  - If this is the last byte (`wordpos=WORDS-1`, `bytepos=BPW-1`): return to IDLE.
- Byte selection: physical byte index = `endianness` ? BPW-1-`bytepos` : `bytepos`. Data is read from `data_buffer` when each byte is loaded, so the caller holds each word stable until its last `byteend`.
- Counters:
  - Bit-timing counter is DIV_W wide and compares against the latched div.
  - `div=0` is legal and gives 1 cycle per bit.
  - No wrap is possible beyond `wordpos=WORDS-1`.
- `start` while busy: ignored; no queueing.
- `start` held high continuously: a new buffer begins on the cycle after returning to IDLE.

## Timing
- Reset values: `tx=1`, `busy=0`, `done=0`, `wordpos=0`, `bytepos=0`, `bytestart=0`, `byteend=0`, state IDLE, all counters 0.
- Reset mid-frame: all of the above apply on the next clock edge. The frame is truncated and no `done` is produced.
- Start response: `start` sampled high at edge N gives `tx=0`, `busy=1` and `bytestart=1` from cycle N+1.
- Frame length F = (1+8+P+STOP_BITS)*(div+1) cycles, where P = 1 with parity, 0 without.
- Buffer duration: exactly WORDS*BPW*F cycles of `busy=1`.
- End of buffer: `done` and the last `byteend` coincide on the final busy cycle. `busy=0` on the following cycle.
- `wordpos` and `bytepos` change on the same cycle as the next `bytestart`.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - Adds input port `parity_odd` (1 bit), sampled at `start`.
  - Adds state PARITY: one bit time after DATA, `tx` = XOR of the 8 data bits, XOR `parity_odd`.
  - P = 1.
- Undefined: no `parity_odd` port, no PARITY state, P = 0.

## Structure
- Package `uart_pkg` holds:
  - `uart_tx_state_e` enum.
  - Framing constants: start bit level 0, idle/stop level 1, data bits 8.
  - A bytes-per-word helper function.
- Sub-module `uart_baud_tick`: loadable down-counter of width DIV_W, emitting a one-cycle `bit_end` pulse every div+1 cycles. It restarts when the FSM loads a new bit.

## Test plan
- Reset/idle: `rst` held 3 cycles, then released with no `start` → `tx=1`, all outputs 0, for 100 cycles.
- Little-endian frame (WORDS=2, WORD_W=16, div=3, STOP_BITS=1, word0=0x12A5, word1=0x3C01, `endianness=0`) → bytes on the line A5, 12, 01, 3C. Each frame is 0, LSB-first data, 1; 40 cycles per byte; `done` at cycle 160 after `start`.
- Big-endian, same buffer (`endianness=1`) → byte order 12, A5, 3C, 01; `bytepos` sequence 0,1,0,1; `wordpos` sequence 0,0,1,1.
- Divisor edge (`div=0`, STOP_BITS=2) → each bit lasts 1 cycle; 11-cycle frames; `start` pulsed again while busy is ignored.
- Reset mid-frame: `rst` asserted during DATA bit 4 of byte 1 → `tx=1` and `busy=0` next cycle; no `done`; a fresh `start` then sends from word0 byte0.
- Parity (`UART_TX_PARITY_EN`, `parity_odd=0`) sending 0xA5 → parity bit 0. With `parity_odd=1` → parity bit 1. Frame length 44 cycles at div=3.
